// File: rtl/text_entry_ctrl.sv
// Keyboard-to-tile-RAM text entry controller: cursor tracking, backspace,
// line wrap with hardware scrolling, and line/screen clear sequencing.
module text_entry_ctrl #(
    parameter int unsigned COLS = 80,
    parameter int unsigned ROWS = 30,
    parameter logic [7:0]  FILL = 8'h20,
    localparam int unsigned CW  = $clog2(COLS),
    localparam int unsigned RW  = $clog2(ROWS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          key_valid,
    input  logic [7:0]    key_ascii,
    output logic          key_ready,
    output logic          wr_en,
    output logic [RW-1:0] wr_row,
    output logic [CW-1:0] wr_col,
    output logic [7:0]    wr_data,
    output logic [RW-1:0] cur_row,
    output logic [CW-1:0] cur_col,
    output logic [RW-1:0] top_row,
    output logic          busy
);

    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);

    typedef enum logic [1:0] {StIdle, StClrLine, StClrAll} state_e;

    state_e        state;
    logic [RW-1:0] clr_row;
    logic [CW-1:0] clr_col;
    logic [RW-1:0] cur_phys;
    logic          accept;
    logic          printable;
    logic          do_newline;

    // (top + r) mod ROWS without widening: wrap when top exceeds the headroom above r.
    function automatic logic [RW-1:0] phys_row(input logic [RW-1:0] top, input logic [RW-1:0] r);
        if (top > ROW_MAX - r) begin
            return top - (ROW_MAX - r) - RW'(1);
        end
        return top + r;
    endfunction

    always_comb begin
        key_ready  = (state == StIdle) && !rst;
        busy       = (state != StIdle);
        accept     = key_valid && key_ready;
        printable  = (key_ascii >= 8'h20) && (key_ascii <= 8'h7E);
        do_newline = accept && ((printable && cur_col == COL_MAX) || key_ascii == 8'h0D);
        cur_phys   = phys_row(top_row, cur_row);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= StClrAll;
            clr_row <= '0;
            clr_col <= '0;
            wr_en   <= 1'b0;
            wr_row  <= '0;
            wr_col  <= '0;
            wr_data <= '0;
            cur_row <= '0;
            cur_col <= '0;
            top_row <= '0;
        end else begin
            wr_en <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (accept) begin
                        if (printable) begin
                            wr_en   <= 1'b1;
                            wr_data <= key_ascii;
                            wr_row  <= cur_phys;
                            wr_col  <= cur_col;
                            cur_col <= cur_col + CW'(1);
                        end else if (key_ascii == 8'h08 && cur_col != '0) begin
                            wr_en   <= 1'b1;
                            wr_data <= FILL;
                            wr_row  <= cur_phys;
                            wr_col  <= cur_col - CW'(1);
                            cur_col <= cur_col - CW'(1);
                        end else if (key_ascii == 8'h0C) begin
                            cur_row <= '0;
                            cur_col <= '0;
                            top_row <= '0;
                            clr_row <= '0;
                            clr_col <= '0;
                            state   <= StClrAll;
                        end
                    end
                    // Overrides the column advance above when the key wraps.
                    if (do_newline) begin
                        cur_col <= '0;
                        if (cur_row == ROW_MAX) begin
                            top_row <= (top_row == ROW_MAX) ? '0 : top_row + RW'(1);
                            clr_row <= top_row;
                            clr_col <= '0;
                            state   <= StClrLine;
                        end else begin
                            cur_row <= cur_row + RW'(1);
                        end
                    end
                end
                StClrLine: begin
                    wr_en   <= 1'b1;
                    wr_data <= FILL;
                    wr_row  <= clr_row;
                    wr_col  <= clr_col;
                    if (clr_col == COL_MAX) begin
                        clr_col <= '0;
                        state   <= StIdle;
                    end else begin
                        clr_col <= clr_col + CW'(1);
                    end
                end
                StClrAll: begin
                    wr_en   <= 1'b1;
                    wr_data <= FILL;
                    wr_row  <= clr_row;
                    wr_col  <= clr_col;
                    if (clr_col == COL_MAX) begin
                        clr_col <= '0;
                        if (clr_row == ROW_MAX) begin
                            clr_row <= '0;
                            state   <= StIdle;
                        end else begin
                            clr_row <= clr_row + RW'(1);
                        end
                    end else begin
                        clr_col <= clr_col + CW'(1);
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_text_entry_ctrl.sv
// Bench for text_entry_ctrl: directed scenarios then random keys, checked
// cycle by cycle against a queue-based screen model.
module tb_text_entry_ctrl;

    localparam int COLS = 4;
    localparam int ROWS = 3;
    localparam int FILL = 8'h20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0;
    logic [7:0] key_ascii = 8'h00;
    logic       key_ready, wr_en, busy;
    logic [1:0] wr_row, wr_col, cur_row, cur_col, top_row;
    logic [7:0] wr_data;

    text_entry_ctrl #(.COLS(COLS), .ROWS(ROWS), .FILL(8'h20)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_ascii (key_ascii),
        .key_ready (key_ready),
        .wr_en     (wr_en),
        .wr_row    (wr_row),
        .wr_col    (wr_col),
        .wr_data   (wr_data),
        .cur_row   (cur_row),
        .cur_col   (cur_col),
        .top_row   (top_row),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit we;
        int row;
        int col;
        int data;
    } item_t;

    item_t q[$];
    int    m_row = 0, m_col = 0, m_top = 0;
    int    checks = 0, errors = 0;

    function automatic item_t wr_item(int r, int c, int d);
        item_t it;
        it.we = 1'b1; it.row = r; it.col = c; it.data = d;
        return it;
    endfunction

    function automatic item_t idle_item();
        item_t it;
        it.we = 1'b0; it.row = 0; it.col = 0; it.data = 0;
        return it;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected per-cycle outputs for one accepted key, first entry = next cycle.
    task automatic apply_key(input int k, output item_t l[$]);
        bit nl;
        l = {};
        nl = 1'b0;
        if (k >= 8'h20 && k <= 8'h7E) begin
            l.push_back(wr_item((m_top + m_row) % ROWS, m_col, k));
            if (m_col == COLS - 1) nl = 1'b1;
            else m_col++;
        end else if (k == 8'h0D) begin
            l.push_back(idle_item());
            nl = 1'b1;
        end else if (k == 8'h08 && m_col > 0) begin
            m_col--;
            l.push_back(wr_item((m_top + m_row) % ROWS, m_col, FILL));
        end else if (k == 8'h0C) begin
            m_row = 0; m_col = 0; m_top = 0;
            l.push_back(idle_item());
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) l.push_back(wr_item(r, c, FILL));
        end else begin
            l.push_back(idle_item());
        end
        if (nl) begin
            m_col = 0;
            if (m_row < ROWS - 1) begin
                m_row++;
            end else begin
                for (int c = 0; c < COLS; c++) l.push_back(wr_item(m_top, c, FILL));
                m_top = (m_top + 1) % ROWS;
            end
        end
    endtask

    task automatic step(input logic r, input logic v, input int k);
        bit    exp_ready, acc;
        item_t exp_it;
        item_t l[$];
        rst = r; key_valid = v; key_ascii = 8'(k);
        #1;
        exp_ready = !r && (q.size() == 0);
        chk("key_ready", {31'd0, key_ready}, {31'd0, exp_ready});
        acc = v && exp_ready;
        @(posedge clk);
        if (r) begin
            m_row = 0; m_col = 0; m_top = 0;
            q = {};
            for (int rr = 0; rr < ROWS; rr++)
                for (int c = 0; c < COLS; c++) q.push_back(wr_item(rr, c, FILL));
            exp_it = idle_item();
        end else if (acc) begin
            apply_key(k, l);
            exp_it = l.pop_front();
            q = l;
        end else if (q.size() > 0) begin
            exp_it = q.pop_front();
        end else begin
            exp_it = idle_item();
        end
        #1;
        chk("wr_en", {31'd0, wr_en}, {31'd0, exp_it.we});
        if (exp_it.we || r) begin
            chk("wr_row", {30'd0, wr_row}, exp_it.row);
            chk("wr_col", {30'd0, wr_col}, exp_it.col);
            chk("wr_data", {24'd0, wr_data}, exp_it.data);
        end
        chk("cur_row", {30'd0, cur_row}, m_row);
        chk("cur_col", {30'd0, cur_col}, m_col);
        chk("top_row", {30'd0, top_row}, m_top);
        chk("busy", {31'd0, busy}, {31'd0, (q.size() != 0)});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0);
    endtask

    initial begin
        int sel, key;
        // Reset and the full power-on clear
        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b1, "X");
        step(1'b1, 1'b0, 0);
        idle(13);
        // Back-to-back printable keys
        step(1'b0, 1'b1, "A");
        step(1'b0, 1'b1, "B");
        idle(1);
        // Home, then five keys wrapping onto row 1, then fill to (2,3)
        step(1'b0, 1'b1, 8'h0C);
        idle(13);
        for (int i = 0; i < 11; i++) step(1'b0, 1'b1, "a" + i);
        // Wrap at the bottom-right: scroll and line clear; held key waits
        step(1'b0, 1'b1, "Z");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, "y");
        idle(1);
        // Backspace cases
        step(1'b0, 1'b1, 8'h0C);
        idle(13);
        step(1'b0, 1'b1, 8'h0D);
        step(1'b0, 1'b1, "p");
        step(1'b0, 1'b1, "q");
        step(1'b0, 1'b1, 8'h08);
        step(1'b0, 1'b1, 8'h08);
        step(1'b0, 1'b1, 8'h08);
        step(1'b0, 1'b1, 8'h07);
        step(1'b0, 1'b1, 8'hC5);
        // Reset in the second cycle of a line clear, key held throughout
        step(1'b0, 1'b1, 8'h0D);
        step(1'b0, 1'b1, 8'h0D);
        step(1'b0, 1'b1, "Q");
        step(1'b1, 1'b1, "Q");
        step(1'b1, 1'b1, "Q");
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, "Q");
        // Random traffic
        for (int i = 0; i < 400; i++) begin
            sel = int'($urandom_range(0, 19));
            if (sel < 10)       key = int'($urandom_range(8'h20, 8'h7E));
            else if (sel < 13)  key = 8'h0D;
            else if (sel < 16)  key = 8'h08;
            else if (sel == 16) key = ($urandom_range(0, 3) == 0) ? 8'h0C : 8'h41;
            else if (sel == 17) key = int'($urandom_range(8'h7F, 8'hFF));
            else                key = int'($urandom_range(0, 8'h1F));
            step(($urandom_range(0, 60) == 0), ($urandom_range(0, 3) != 0), key);
        end
        idle(16);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
